imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the 5-stage pipeline. It receives a program as an 8-bit byte stream with a valid/ready handshake and assembles little-endian 32-bit words. It writes them sequentially into the instruction memory write port and holds the pipeline in reset until the image is complete. It then releases the pipeline reset so fetch starts at address 0 with a fully populated memory.

## Interface
- ADDR_WIDTH, 10, instruction memory word-address width; capacity is 2^ADDR_WIDTH words.
- TIMEOUT, 1000, maximum idle cycles between accepted bytes once a load has begun (≥2).

- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader accepts a byte this cycle
- reload  input  1  single-cycle request to reload; honoured only in RUN or ERROR
- imem_we  output  1  instruction memory write strobe
- imem_addr  output  ADDR_WIDTH  word address of the write
- imem_wdata  output  32  word to write
- core_rst  output  1  active-low reset to the pipeline; 0 holds the core in reset
- load_done  output  1  image loaded and core released
- load_err  output  1  sticky error flag

## Operation
- The stream format is fixed: count low byte, count high byte (16-bit word count N), then N words of 4 bytes each, least-significant byte first.
- States:
  - HDR0, HDR1: capture the count.
  - DATA: assemble and write words.
  - CSUM: checksum byte, only with the macro.
  - RUN: core released.
  - ERROR: load failed.
- A byte is accepted when rx_valid && rx_ready.
- rx_ready is 1 in HDR0, HDR1, DATA and CSUM. It is 0 in RUN and ERROR, and 0 while rst=0.
- Header check after HDR1:
  - N > 2^ADDR_WIDTH → ERROR.
  - N = 0 → CSUM if enabled, else RUN.
  - Otherwise → DATA.
- DATA: a 2-bit byte counter and a word counter. On the 4th byte of a word, the write fires and the word counter increments. After word N the loader goes to CSUM or RUN.
- The word address starts at 0 and increments by 1 per word. It never wraps, because the N limit above forbids it.
- Timeout: an idle counter clears on every accepted byte. It counts only in HDR1, DATA or CSUM, i.e. after the first byte is accepted. When it reaches TIMEOUT the loader goes to ERROR, and any partial word is discarded.
- ERROR sets load_err=1. core_rst stays 0 and load_done stays 0.
- reload in RUN or ERROR:
  - Next cycle: state HDR0, core_rst=0, load_done=0, load_err=0, counters cleared.
  - reload in any other state is ignored.

## Timing
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, load_done=0, load_err=0. State is HDR0.
- The first cycle after rst deasserts already has rx_ready=1.
- Throughput is one byte per cycle with no bubbles, including across word boundaries.
- imem_we is registered:
  - It is high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - imem_addr and imem_wdata are valid in that same cycle.
- Release of core_rst and load_done:
  - Both go 1 two cycles after the final byte is accepted. The final byte is the last data byte, the checksum byte, or the count high byte when N=0.
  - Without the macro, this is one cycle after the last imem_we.
  - The two outputs change together and are glitch-free.
- When rst asserts mid-load, all outputs return to their reset values immediately. Partially written memory contents are not cleared.
- If reload coincides with a timeout or with rx_valid, reload wins in RUN and ERROR. In those states rx_ready is 0, so no byte is lost.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - A trailing byte follows the data. It must equal the XOR of all header and data bytes.
  - Match → RUN.
  - Mismatch → ERROR. Every word has already been written, but the core stays in reset.
- Undefined: there is no CSUM state, and RUN follows the last data word directly.

## Test plan
- N=2, bytes 02 00 13 00 00 00 93 00 10 00, rx_valid continuous:
  - imem_we at addr 0 with 0x00000013, then addr 1 with 0x00100093.
  - core_rst and load_done rise 2 cycles after the last byte.
- The same image with rx_valid toggling every other cycle gives identical writes; only the timing stretches, and no write is duplicated.
- N=0x0401 with ADDR_WIDTH=10 → load_err=1 after the header, core_rst stays 0, no imem_we.
- Stall TIMEOUT cycles after 2 data bytes → ERROR. Then reload → HDR0, load_err=0, and a clean reload succeeds.
- With IMEM_LOADER_CHECKSUM_EN, 01 00 13 00 00 00 followed by checksum 12 → RUN. The same image with checksum 00 → ERROR, while the word at addr 0 is still written.
- Assert rst in the middle of word 1 → all outputs return to reset values at once. Reload the full image → correct writes starting from addr 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// master drives the byte stream and reload; slave is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  reload;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rst;
  logic                  load_done;
  logic                  load_err;

  modport master (
    output rx_data, rx_valid, reload,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err
  );

  modport slave (
    input  rx_data, rx_valid, reload,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> LE words into imem, core held in reset until done; write 1 cycle, release 2 cycles after last byte.
// One byte/cycle, rx_ready low only in RUN/ERROR/reset; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 1000
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERROR} state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AfterData = CSUM;
`else
  localparam state_t AfterData = RUN;
`endif

  localparam int             IdleW    = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);
  localparam logic [31:0]    MaxWords = 32'd1 << ADDR_WIDTH;

  state_t                state;
  logic [7:0]            countLo;
  logic [15:0]           wordCount;
  logic [1:0]            byteCnt;
  logic [ADDR_WIDTH:0]   wordCnt;
  logic [23:0]           wordBuf;
  logic [IdleW-1:0]      idleCnt;
  logic                  imemWe;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic [31:0]           imemWdata;
  logic                  coreRst;
  logic                  loadDone;
  logic                  loadErr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic        rdyState;
  logic        rxReady;
  logic        accept;
  logic        idleTick;
  logic        timedOut;
  logic        lastWord;
  logic [15:0] hdrCount;

  always_comb begin
    rdyState = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
    // Gated by rst so the loader never advertises ready while held in reset.
    rxReady  = rdyState && rst;
    accept   = bus.rx_valid && rxReady;
    idleTick = !accept && ((state == HDR1) || (state == DATA) || (state == CSUM));
    timedOut = idleTick && (idleCnt == IdleLast);
    lastWord = (32'(wordCnt) + 32'd1) == 32'(wordCount);
    hdrCount = {bus.rx_data, countLo};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HDR0;
      countLo   <= '0;
      wordCount <= '0;
      byteCnt   <= '0;
      wordCnt   <= '0;
      wordBuf   <= '0;
      idleCnt   <= '0;
      imemWe    <= 1'b0;
      imemAddr  <= '0;
      imemWdata <= '0;
      coreRst   <= 1'b0;
      loadDone  <= 1'b0;
      loadErr   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      imemWe <= 1'b0;
      if (accept) begin
        idleCnt <= '0;
      end else if (idleTick) begin
        idleCnt <= idleCnt + 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept && (state != CSUM)) begin
        csum <= csum ^ bus.rx_data;
      end
`endif
      case (state)
        HDR0: begin
          if (accept) begin
            countLo <= bus.rx_data;
            state   <= HDR1;
          end
        end
        HDR1: begin
          if (timedOut) begin
            state   <= ERROR;
            loadErr <= 1'b1;
          end else if (accept) begin
            wordCount <= hdrCount;
            wordCnt   <= '0;
            byteCnt   <= '0;
            if (32'(hdrCount) > MaxWords) begin
              state   <= ERROR;
              loadErr <= 1'b1;
            end else if (hdrCount == 16'd0) begin
              state <= AfterData;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (timedOut) begin
            state   <= ERROR;
            loadErr <= 1'b1;
          end else if (accept) begin
            byteCnt <= byteCnt + 2'd1;
            wordBuf <= {bus.rx_data, wordBuf[23:8]};
            if (byteCnt == 2'd3) begin
              imemWe    <= 1'b1;
              imemAddr  <= wordCnt[ADDR_WIDTH-1:0];
              imemWdata <= {bus.rx_data, wordBuf};
              wordCnt   <= wordCnt + 1'b1;
              if (lastWord) begin
                state <= AfterData;
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (timedOut) begin
            state   <= ERROR;
            loadErr <= 1'b1;
          end else if (accept) begin
            if (bus.rx_data == csum) begin
              state <= RUN;
            end else begin
              state   <= ERROR;
              loadErr <= 1'b1;
            end
          end
        end
`endif
        RUN, ERROR: begin
          if (bus.reload) begin
            state    <= HDR0;
            coreRst  <= 1'b0;
            loadDone <= 1'b0;
            loadErr  <= 1'b0;
            byteCnt  <= '0;
            wordCnt  <= '0;
            idleCnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end else if (state == RUN) begin
            // Registered a cycle after entering RUN so release trails the last write.
            coreRst  <= 1'b1;
            loadDone <= 1'b1;
          end
        end
        default: state <= HDR0;
      endcase
    end
  end

  assign bus.rx_ready   = rxReady;
  assign bus.imem_we    = imemWe;
  assign bus.imem_addr  = imemAddr;
  assign bus.imem_wdata = imemWdata;
  assign bus.core_rst   = coreRst;
  assign bus.load_done  = loadDone;
  assign bus.load_err   = loadErr;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs driven on negedge, outputs sampled on negedge.
module tb_imem_loader;
  localparam int AW = 10;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus();
  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] wrAddr[$];
  logic [31:0]   wrData[$];
  logic [7:0]    img[$];

  always @(negedge clk) begin
    if (rst && bus.imem_we) begin
      wrAddr.push_back(bus.imem_addr);
      wrData.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (img[i]) x ^= img[i];
    img.push_back(x);
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic rl);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.reload   = rl;
    #1;
    vectors++;
    if (bus.rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_ready_on_byte: got %b expected 1 (byte %h)", bus.rx_ready, b);
    end
    @(negedge clk);
    bus.reload = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_image(input bit gap, input int reloadAt);
    foreach (img[i]) begin
      if (gap && i > 0) idle(1);
      send_byte(img[i], i == reloadAt);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
  endtask

  task automatic clear_writes();
    wrAddr.delete();
    wrData.delete();
  endtask

  task automatic load_basic();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    add_csum();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.reload = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.rx_ready, bus.imem_we, bus.core_rst, bus.load_done, bus.load_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.rx_ready, bus.imem_we, bus.core_rst, bus.load_done, bus.load_err});
    end
    vectors++;
    if (bus.imem_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h expected 0", bus.imem_addr);
    end
    vectors++;
    if (bus.imem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_wdata: got %h expected 0", bus.imem_wdata);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b expected 1", bus.rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_writes();
    load_basic();
    send_image(1'b0, -1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    vectors++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 10'd1, 32'h0010_0093}) begin
      miscompares++;
      $display("FAIL last_write: got we=%b addr=%h data=%h expected we=1 addr=001 data=00100093",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
`endif
    vectors++;
    if ({bus.core_rst, bus.load_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_early_release: got %b expected 00", {bus.core_rst, bus.load_done});
    end
    idle(1);
    vectors++;
    if ({bus.core_rst, bus.load_done, bus.load_err, bus.rx_ready} !== 4'b1100) begin
      miscompares++;
      $display("FAIL basic_release: got %b expected 1100",
               {bus.core_rst, bus.load_done, bus.load_err, bus.rx_ready});
    end
    vectors++;
    if (wrAddr.size() !== 2) begin
      miscompares++;
      $display("FAIL basic_write_count: got %0d expected 2", wrAddr.size());
    end else begin
      vectors++;
      if ({wrAddr[0], wrData[0], wrAddr[1], wrData[1]} !== {10'd0, 32'h13, 10'd1, 32'h0010_0093}) begin
        miscompares++;
        $display("FAIL basic_writes: got %h:%h %h:%h expected 000:00000013 001:00100093",
                 wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
      end
    end
  endtask

  task automatic test_gapped();
    do_reload();
    vectors++;
    if ({bus.core_rst, bus.load_done, bus.load_err, bus.rx_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reload_state: got %b expected 0001",
               {bus.core_rst, bus.load_done, bus.load_err, bus.rx_ready});
    end
    clear_writes();
    load_basic();
    send_image(1'b1, 3);
    vectors++;
    if (bus.core_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL gapped_early_release: got %b expected 0", bus.core_rst);
    end
    idle(1);
    vectors++;
    if ({bus.core_rst, bus.load_done} !== 2'b11) begin
      miscompares++;
      $display("FAIL gapped_release: got %b expected 11", {bus.core_rst, bus.load_done});
    end
    vectors++;
    if (wrAddr.size() !== 2) begin
      miscompares++;
      $display("FAIL gapped_write_count: got %0d expected 2", wrAddr.size());
    end else begin
      vectors++;
      if ({wrAddr[0], wrData[0], wrAddr[1], wrData[1]} !== {10'd0, 32'h13, 10'd1, 32'h0010_0093}) begin
        miscompares++;
        $display("FAIL gapped_writes: got %h:%h %h:%h expected 000:00000013 001:00100093",
                 wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
      end
    end
  endtask

  task automatic test_n_zero();
    do_reload();
    clear_writes();
    img = '{8'h00, 8'h00};
    add_csum();
    send_image(1'b0, -1);
    vectors++;
    if (bus.core_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL nzero_early_release: got %b expected 0", bus.core_rst);
    end
    idle(1);
    vectors++;
    if ({bus.core_rst, bus.load_done, bus.load_err} !== 3'b110) begin
      miscompares++;
      $display("FAIL nzero_release: got %b expected 110", {bus.core_rst, bus.load_done, bus.load_err});
    end
    vectors++;
    if (wrAddr.size() !== 0) begin
      miscompares++;
      $display("FAIL nzero_writes: got %0d expected 0", wrAddr.size());
    end
  endtask

  task automatic test_oversize();
    do_reload();
    clear_writes();
    img = '{8'h01, 8'h04};
    send_image(1'b0, -1);
    vectors++;
    if (bus.load_err !== 1'b1) begin
      miscompares++;
      $display("FAIL oversize_err: got %b expected 1", bus.load_err);
    end
    idle(5);
    vectors++;
    if ({bus.load_err, bus.core_rst, bus.load_done, bus.rx_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL oversize_hold: got %b expected 1000",
               {bus.load_err, bus.core_rst, bus.load_done, bus.rx_ready});
    end
    vectors++;
    if (wrAddr.size() !== 0) begin
      miscompares++;
      $display("FAIL oversize_writes: got %0d expected 0", wrAddr.size());
    end
  endtask

  task automatic test_timeout();
    do_reload();
    vectors++;
    if ({bus.load_err, bus.rx_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL err_cleared: got %b expected 01", {bus.load_err, bus.rx_ready});
    end
    clear_writes();
    img = '{8'h00, 8'h04};
    send_image(1'b0, -1);
    vectors++;
    if ({bus.load_err, bus.rx_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL max_count_accepted: got %b expected 01", {bus.load_err, bus.rx_ready});
    end
    idle(TO - 2);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    idle(1);
    vectors++;
    if (bus.load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL short_stall_err: got %b expected 0", bus.load_err);
    end
    idle(2 * TO);
    vectors++;
    if ({bus.load_err, bus.rx_ready, bus.core_rst} !== 3'b100) begin
      miscompares++;
      $display("FAIL timeout_err: got %b expected 100", {bus.load_err, bus.rx_ready, bus.core_rst});
    end
    vectors++;
    if (wrAddr.size() !== 0) begin
      miscompares++;
      $display("FAIL timeout_writes: got %0d expected 0", wrAddr.size());
    end
    do_reload();
    vectors++;
    if ({bus.load_err, bus.rx_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL timeout_reload: got %b expected 01", {bus.load_err, bus.rx_ready});
    end
    load_basic();
    send_image(1'b0, -1);
    idle(1);
    vectors++;
    if ({bus.core_rst, bus.load_done, bus.load_err} !== 3'b110) begin
      miscompares++;
      $display("FAIL timeout_recover: got %b expected 110", {bus.core_rst, bus.load_done, bus.load_err});
    end
    vectors++;
    if (wrAddr.size() !== 2) begin
      miscompares++;
      $display("FAIL recover_write_count: got %0d expected 2", wrAddr.size());
    end else begin
      vectors++;
      if ({wrAddr[0], wrData[0], wrAddr[1], wrData[1]} !== {10'd0, 32'h13, 10'd1, 32'h0010_0093}) begin
        miscompares++;
        $display("FAIL recover_writes: got %h:%h %h:%h expected 000:00000013 001:00100093",
                 wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reload();
    clear_writes();
    img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send_image(1'b0, -1);
    idle(1);
    vectors++;
    if ({bus.core_rst, bus.load_done, bus.load_err} !== 3'b110) begin
      miscompares++;
      $display("FAIL csum_good: got %b expected 110", {bus.core_rst, bus.load_done, bus.load_err});
    end
    do_reload();
    img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    send_image(1'b0, -1);
    idle(2);
    vectors++;
    if ({bus.core_rst, bus.load_done, bus.load_err} !== 3'b001) begin
      miscompares++;
      $display("FAIL csum_bad: got %b expected 001", {bus.core_rst, bus.load_done, bus.load_err});
    end
    vectors++;
    if (wrAddr.size() !== 2) begin
      miscompares++;
      $display("FAIL csum_write_count: got %0d expected 2", wrAddr.size());
    end else begin
      vectors++;
      if ({wrAddr[0], wrData[0], wrAddr[1], wrData[1]} !== {10'd0, 32'h13, 10'd0, 32'h13}) begin
        miscompares++;
        $display("FAIL csum_writes: got %h:%h %h:%h expected 000:00000013 000:00000013",
                 wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reload();
    load_basic();
    for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
    bus.rx_valid = 1'b0;
    vectors++;
    if (bus.imem_wdata !== 32'h13) begin
      miscompares++;
      $display("FAIL mid_word0: got %h expected 00000013", bus.imem_wdata);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.rx_ready, bus.imem_we, bus.core_rst, bus.load_done, bus.load_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_reset_flags: got %b expected 00000",
               {bus.rx_ready, bus.imem_we, bus.core_rst, bus.load_done, bus.load_err});
    end
    vectors++;
    if ({bus.imem_addr, bus.imem_wdata} !== 42'h0) begin
      miscompares++;
      $display("FAIL mid_reset_bus: got addr=%h data=%h expected 0 0", bus.imem_addr, bus.imem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_writes();
    send_image(1'b0, -1);
    idle(1);
    vectors++;
    if ({bus.core_rst, bus.load_done} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_reload_release: got %b expected 11", {bus.core_rst, bus.load_done});
    end
    vectors++;
    if (wrAddr.size() !== 2) begin
      miscompares++;
      $display("FAIL mid_write_count: got %0d expected 2", wrAddr.size());
    end else begin
      vectors++;
      if ({wrAddr[0], wrData[0], wrAddr[1], wrData[1]} !== {10'd0, 32'h13, 10'd1, 32'h0010_0093}) begin
        miscompares++;
        $display("FAIL mid_writes: got %h:%h %h:%h expected 000:00000013 001:00100093",
                 wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_n_zero();
    test_oversize();
    test_timeout();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
